inv_cordic: RTL and testbench
=============================

# inv_cordic

Polar-to-rectangular CORDIC in rotation mode: the resynthesis leg of the voice path. It takes one frequency bin as {magnitude, phase}, with phase in 1/64-degree units (45° = 2880, 180° = 11520). It returns {real, imag} packed like the FFT output word, ready for the IFFT. One bin is processed at a time, with a valid/ready input handshake and a one-cycle output strobe.

## Interface
- `ITER`, 8: CORDIC micro-rotations. Fixed at 8; the atan table and gain constant assume it.
- `LEN_SCALE`, 39: gain-compensation multiplier applied as (mag*LEN_SCALE)>>6, ≈1/1.6468.
- `clk` in 1: single clock, all state on posedge.
- `rst` in 1: asynchronous, active-high reset.
- `polar_valid` in 1: input bin present.
- `polar_ready` out 1: block idle and able to accept.
- `polar_data` in 32: [31:16] magnitude (unsigned); [15:0] phase (signed, 1/64°).
- `polar_freq` in 5: bin index, carried through unchanged.
- `polar_last` in 1: last bin of frame, carried through.
- `ifft_valid` out 1: one-cycle strobe, output word valid.
- `ifft_data` out 32: [31:16] real, [15:0] imag, both signed and saturated.
- `ifft_freq` out 5: bin index of this output.
- `ifft_last` out 1: copy of `polar_last` for this bin.

## Operation
- Atan table, in 1/64°, i=0..7: 2880, 1700, 898, 456, 229, 115, 57, 29.
- FSM states: IDLE and ROTATE. `polar_ready` = (state==IDLE).
- **Accept:** an edge with `polar_valid && polar_ready`. At that edge:
  - latch `polar_freq` and `polar_last`;
  - load x, y, z as below;
  - set iteration count k=0 and go to ROTATE.
- **Phase wrap (combinational, on accept):** p = phase.
  - If p ≥ 11520, p −= 23040.
  - If p < −11520, p += 23040.
  - A single wrap covers the full 16-bit range.
- **Prescale:** m = (mag*39)>>6. Product is computed in 22 bits unsigned; m fits 16 bits.
- **Quadrant fold:**
  - If p > 5760: x0 = −m, y0 = 0, z0 = p − 11520.
  - If p < −5760: x0 = −m, y0 = 0, z0 = p + 11520.
  - Otherwise: x0 = m, y0 = 0, z0 = p.
  - Afterwards |z0| ≤ 5760.
- **ROTATE, iteration k:** x, y are 18-bit signed; z is 16-bit signed; shifts are arithmetic.
  - If z ≥ 0: x' = x − (y>>>k), y' = y + (x>>>k), z' = z − atan[k].
  - Else: x' = x + (y>>>k), y' = y − (x>>>k), z' = z + atan[k].
  - k increments each cycle.
- **Finish:** on the edge that completes k=7:
  - register sat16(x'), sat16(y') into `ifft_data`;
  - drive `ifft_freq` and `ifft_last`;
  - assert `ifft_valid`;
  - return to IDLE.
- **sat16:** values > 32767 → 32767; values < −32768 → −32768.
- `ifft_data`, `ifft_freq` and `ifft_last` hold until the next finish. `ifft_valid` is high for exactly one cycle.
- No output backpressure. The downstream side must take the word on the strobe.
- `polar_valid` while busy is ignored. The source must hold the bin until `polar_ready`.

## Timing
- **Latency:** accept at edge E0; `ifft_valid` high in the cycle after E8, i.e. 8 cycles.
- **Throughput:** `polar_ready` is high again in the cycle after E8. The next accept can occur at E9, giving 1 bin per 9 cycles. `ifft_valid` and the next accept may coincide.
- **Reset:**
  - state = IDLE, x = y = z = k = 0;
  - `polar_ready` = 1, `ifft_valid` = 0, `ifft_data` = 0, `ifft_freq` = 0, `ifft_last` = 0.
- **Reset mid-ROTATE:** the in-flight bin is discarded and no `ifft_valid` is produced. The first edge after release may accept.
- **Accuracy:** result within ±(1% of mag + 4 LSB) per component, before saturation.

## Test plan
- **Cardinal phases, mag=1000:**
  - phase 0 → re≈1000, im≈0;
  - 5760 → re≈0, im≈1000;
  - −5760 → im≈−1000;
  - 11519 → re≈−1000, im≈0.
  - All within tolerance. `ifft_freq` echoes the input.
- **Diagonal:** mag=32767, phase=2880 → re ≈ im ≈ 23170, both positive, no wrap.
- **Saturation and wrap:**
  - mag=32767, phase=0 → re = 32767 (saturated), im≈0;
  - phase=23040+2880 (wraps) → same result as phase=2880.
- **Handshake:** hold `polar_valid`=1 with 3 distinct bins; `polar_last`=1 on the third.
  - Accepts occur 9 cycles apart.
  - 3 `ifft_valid` pulses, each 1 cycle wide, in order.
  - `ifft_last` = 1 only on the third.
- **Latency and ready:** single accept at E0.
  - `polar_ready` = 0 from after E0 through E8.
  - `ifft_valid` asserted in the cycle after E8.
  - An input offered at E3 is ignored.
- **Reset mid-op:** assert `rst` asynchronously (off-edge) at k=4.
  - All outputs go to reset values immediately; no `ifft_valid`.
  - After release, a new bin (mag=500, phase=0) completes with re≈500.

Source files
------------

// File: rtl/inv_cordic.sv
// Rotation-mode CORDIC: turns one {magnitude, phase} bin into a saturated
// {real, imag} word, one bin per 9 cycles with a one-cycle output strobe.
module inv_cordic #(
  parameter int ITER      = 8,
  parameter int LEN_SCALE = 39
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        polar_valid,
  output logic        polar_ready,
  input  logic [31:0] polar_data,
  input  logic [4:0]  polar_freq,
  input  logic        polar_last,
  output logic        ifft_valid,
  output logic [31:0] ifft_data,
  output logic [4:0]  ifft_freq,
  output logic        ifft_last
);

  localparam int KW = $clog2(ITER);

  typedef enum logic {IDLE, ROTATE} state_t;

  state_t                state_q, state_d;
  logic [KW-1:0]         k_q, k_d;
  logic signed [17:0]    x_q, x_d, y_q, y_d;
  logic signed [15:0]    z_q, z_d;
  logic [4:0]            freq_q, freq_d;
  logic                  last_q, last_d;
  logic                  ifft_valid_q, ifft_valid_d;
  logic [31:0]           ifft_data_q, ifft_data_d;
  logic [4:0]            ifft_freq_q, ifft_freq_d;
  logic                  ifft_last_q, ifft_last_d;

  logic [21:0]           prod;
  logic signed [17:0]    m_s;
  logic signed [16:0]    p_raw, p_wrap, z_fold;
  logic signed [17:0]    x0;
  logic signed [17:0]    x_sh, y_sh, x_n, y_n;
  logic signed [15:0]    z_n;

  // Angles in 1/64 degree for atan(2^-i)
  function automatic logic signed [15:0] atan_lut(input logic [KW-1:0] i);
    case (i)
      3'd0:    return 16'sd2880;
      3'd1:    return 16'sd1700;
      3'd2:    return 16'sd898;
      3'd3:    return 16'sd456;
      3'd4:    return 16'sd229;
      3'd5:    return 16'sd115;
      3'd6:    return 16'sd57;
      default: return 16'sd29;
    endcase
  endfunction

  function automatic logic [15:0] sat16(input logic signed [17:0] v);
    if (v > 18'sd32767)       return 16'h7FFF;
    else if (v < -18'sd32768) return 16'h8000;
    else                      return v[15:0];
  endfunction

  // Input conditioning: gain prescale, phase wrap to +-180 deg, fold to +-90 deg
  always_comb begin
    prod   = 22'(polar_data[31:16]) * 22'(LEN_SCALE);
    m_s    = $signed({2'b00, prod[21:6]});
    p_raw  = $signed({polar_data[15], polar_data[15:0]});
    p_wrap = p_raw;
    if (p_raw >= 17'sd11520)
      p_wrap = p_raw - 17'sd23040;
    else if (p_raw < -17'sd11520)
      p_wrap = p_raw + 17'sd23040;
    x0     = m_s;
    z_fold = p_wrap;
    if (p_wrap > 17'sd5760) begin
      x0     = -m_s;
      z_fold = p_wrap - 17'sd11520;
    end else if (p_wrap < -17'sd5760) begin
      x0     = -m_s;
      z_fold = p_wrap + 17'sd11520;
    end
  end

  always_comb begin
    x_sh = x_q >>> k_q;
    y_sh = y_q >>> k_q;
    if (!z_q[15]) begin
      x_n = x_q - y_sh;
      y_n = y_q + x_sh;
      z_n = z_q - atan_lut(k_q);
    end else begin
      x_n = x_q + y_sh;
      y_n = y_q - x_sh;
      z_n = z_q + atan_lut(k_q);
    end
  end

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    x_d          = x_q;
    y_d          = y_q;
    z_d          = z_q;
    freq_d       = freq_q;
    last_d       = last_q;
    ifft_valid_d = 1'b0;
    ifft_data_d  = ifft_data_q;
    ifft_freq_d  = ifft_freq_q;
    ifft_last_d  = ifft_last_q;
    case (state_q)
      IDLE: begin
        if (polar_valid) begin
          x_d     = x0;
          y_d     = '0;
          z_d     = z_fold[15:0];
          k_d     = '0;
          freq_d  = polar_freq;
          last_d  = polar_last;
          state_d = ROTATE;
        end
      end
      ROTATE: begin
        x_d = x_n;
        y_d = y_n;
        z_d = z_n;
        k_d = k_q + 1'b1;
        if (k_q == KW'(ITER - 1)) begin
          state_d      = IDLE;
          ifft_valid_d = 1'b1;
          ifft_data_d  = {sat16(x_n), sat16(y_n)};
          ifft_freq_d  = freq_q;
          ifft_last_d  = last_q;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      k_q          <= '0;
      x_q          <= '0;
      y_q          <= '0;
      z_q          <= '0;
      freq_q       <= '0;
      last_q       <= 1'b0;
      ifft_valid_q <= 1'b0;
      ifft_data_q  <= '0;
      ifft_freq_q  <= '0;
      ifft_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      x_q          <= x_d;
      y_q          <= y_d;
      z_q          <= z_d;
      freq_q       <= freq_d;
      last_q       <= last_d;
      ifft_valid_q <= ifft_valid_d;
      ifft_data_q  <= ifft_data_d;
      ifft_freq_q  <= ifft_freq_d;
      ifft_last_q  <= ifft_last_d;
    end
  end

  assign polar_ready = (state_q == IDLE);
  assign ifft_valid  = ifft_valid_q;
  assign ifft_data   = ifft_data_q;
  assign ifft_freq   = ifft_freq_q;
  assign ifft_last   = ifft_last_q;

endmodule

// File: tb/tb_inv_cordic.sv
// Directed bench for inv_cordic: exact CORDIC results worked out by hand,
// plus handshake spacing, latency/ready timing and mid-rotation reset.
module tb_inv_cordic;

  logic        clk;
  logic        rst;
  logic        polar_valid;
  logic        polar_ready;
  logic [31:0] polar_data;
  logic [4:0]  polar_freq;
  logic        polar_last;
  logic        ifft_valid;
  logic [31:0] ifft_data;
  logic [4:0]  ifft_freq;
  logic        ifft_last;

  int n_pass   = 0;
  int n_checks = 0;

  int          cyc = 0;
  int          acc_q[$];
  logic [37:0] out_q[$];
  int          wide = 0;
  logic        prev_v = 1'b0;

  inv_cordic #(.ITER(8), .LEN_SCALE(39)) dut (
    .clk         (clk),
    .rst         (rst),
    .polar_valid (polar_valid),
    .polar_ready (polar_ready),
    .polar_data  (polar_data),
    .polar_freq  (polar_freq),
    .polar_last  (polar_last),
    .ifft_valid  (ifft_valid),
    .ifft_data   (ifft_data),
    .ifft_freq   (ifft_freq),
    .ifft_last   (ifft_last)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Records the cycle number of every accepted bin
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && polar_valid && polar_ready)
      acc_q.push_back(cyc);
  end

  // Records every output word and flags strobes wider than one cycle
  always @(negedge clk) begin
    if (ifft_valid) out_q.push_back({ifft_last, ifft_freq, ifft_data});
    if (ifft_valid && prev_v) wide++;
    prev_v = ifft_valid;
  end

  task automatic check(input string tag, input logic [37:0] obs, input logic [37:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Presents one bin at a negedge; it is accepted on the following posedge
  task automatic send_bin(input logic [15:0] mag, input logic [15:0] ph,
                          input logic [4:0] f, input logic l);
    @(negedge clk);
    polar_valid = 1'b1;
    polar_data  = {mag, ph};
    polar_freq  = f;
    polar_last  = l;
    @(negedge clk);
    polar_valid = 1'b0;
  endtask

  task automatic wait_out(output logic [37:0] w, output int lat);
    lat = -1;
    w   = '0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (ifft_valid) begin
        lat = i;
        w   = {ifft_last, ifft_freq, ifft_data};
        break;
      end
    end
  endtask

  task automatic run_bin(input string tag, input logic [15:0] mag, input logic [15:0] ph,
                         input logic [4:0] f, input logic l, input logic [31:0] exp);
    logic [37:0] w;
    int          lat;
    send_bin(mag, ph, f, l);
    wait_out(w, lat);
    check(tag, w, {l, f, exp});
    check({tag, "_lat"}, 38'(lat), 38'd8);
  endtask

  initial begin
    logic [31:0] hs_in [3];
    logic [37:0] hs_exp[3];
    int          rdy_hi;
    int          v_hi;
    logic        ok;

    rst         = 1'b0;
    polar_valid = 1'b0;
    polar_data  = '0;
    polar_freq  = '0;
    polar_last  = 1'b0;

    // Reset state
    #1 rst = 1'b1;
    #2;
    check("reset_ready", 38'(polar_ready), 38'd1);
    check("reset_out", {ifft_valid, ifft_last, ifft_freq, ifft_data}, 38'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Cardinal phases, mag 1000 (prescaled to 609)
    run_bin("ph0",     16'd1000, 16'd0,         5'd1,  1'b0, 32'h03EA_0007);
    run_bin("ph90",    16'd1000, 16'd5760,      5'd2,  1'b0, 32'h0007_03EA);
    run_bin("ph_m90",  16'd1000, 16'(-5760),    5'd3,  1'b0, 32'h0006_FC14);
    run_bin("ph180",   16'd1000, 16'd11519,     5'd4,  1'b0, 32'hFC14_0006);

    // Diagonal, saturation and both wrap directions
    run_bin("diag",    16'd32767, 16'd2880,     5'd10, 1'b0, 32'h5B76_5A2D);
    run_bin("sat_re",  16'd32767, 16'd0,        5'd11, 1'b1, 32'h7FFF_00E8);
    run_bin("wrap_hi", 16'd32767, 16'd25920,    5'd12, 1'b0, 32'h5B76_5A2D);
    run_bin("wrap_lo", 16'd32767, 16'(-20160),  5'd13, 1'b0, 32'h5B76_5A2D);

    // Back-to-back bins with valid held high
    hs_in[0]  = {16'd1000, 16'd0};
    hs_in[1]  = {16'd1000, 16'd5760};
    hs_in[2]  = {16'd500,  16'd0};
    hs_exp[0] = {1'b0, 5'd1, 32'h03EA_0007};
    hs_exp[1] = {1'b0, 5'd2, 32'h0007_03EA};
    hs_exp[2] = {1'b1, 5'd3, 32'h01F5_0003};
    repeat (2) @(negedge clk);
    acc_q.delete();
    out_q.delete();
    wide = 0;
    polar_valid = 1'b1;
    for (int b = 0; b < 3; b++) begin
      polar_data = hs_in[b];
      polar_freq = 5'(b + 1);
      polar_last = (b == 2);
      ok = 1'b0;
      for (int t = 0; t < 20; t++) begin
        @(negedge clk);
        if (acc_q.size() == b + 1) begin
          ok = 1'b1;
          break;
        end
      end
      check($sformatf("hs_accept%0d", b), 38'(ok), 38'd1);
    end
    polar_valid = 1'b0;
    polar_last  = 1'b0;
    repeat (12) @(negedge clk);
    check("hs_gap01", 38'((acc_q.size() == 3) ? acc_q[1] - acc_q[0] : -1), 38'd9);
    check("hs_gap12", 38'((acc_q.size() == 3) ? acc_q[2] - acc_q[1] : -1), 38'd9);
    check("hs_count", 38'(out_q.size()), 38'd3);
    for (int i = 0; i < 3; i++)
      check($sformatf("hs_word%0d", i), (i < out_q.size()) ? out_q[i] : '1, hs_exp[i]);
    check("hs_wide", 38'(wide), 38'd0);

    // Latency and ready, with an ignored offer while busy
    out_q.delete();
    @(negedge clk);
    polar_valid = 1'b1;
    polar_data  = {16'd1000, 16'd0};
    polar_freq  = 5'd5;
    polar_last  = 1'b0;
    @(negedge clk);
    polar_valid = 1'b0;
    rdy_hi = int'(polar_ready);
    v_hi   = int'(ifft_valid);
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      rdy_hi += int'(polar_ready);
      v_hi   += int'(ifft_valid);
      if (n == 2) begin
        polar_valid = 1'b1;
        polar_data  = {16'd2000, 16'd100};
        polar_freq  = 5'd9;
      end
      if (n == 3) polar_valid = 1'b0;
    end
    check("lat_ready_low", 38'(rdy_hi), 38'd0);
    check("lat_no_early", 38'(v_hi), 38'd0);
    @(negedge clk);
    check("lat_valid_e8", 38'(ifft_valid), 38'd1);
    check("lat_ready_e8", 38'(polar_ready), 38'd1);
    check("lat_word", {ifft_last, ifft_freq, ifft_data}, {1'b0, 5'd5, 32'h03EA_0007});
    @(negedge clk);
    check("lat_pulse_end", 38'(ifft_valid), 38'd0);
    repeat (12) @(negedge clk);
    check("lat_ignored", 38'(out_q.size()), 38'd1);

    // Asynchronous reset while k = 4
    out_q.delete();
    send_bin(16'd800, 16'd0, 5'd7, 1'b1);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_ready", 38'(polar_ready), 38'd1);
    check("rst_out", {ifft_valid, ifft_last, ifft_freq, ifft_data}, 38'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("rst_no_out", 38'(out_q.size()), 38'd0);
    run_bin("post_rst", 16'd500, 16'd0, 5'd4, 1'b0, 32'h01F5_0003);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
